// File: rtl/mem_decoder_pkg.sv
// mem_decoder_pkg: types and constants shared by the memory decoder slice.
//   state_t       decoder FSM states (IDLE, BUSY, ERR)
//   SLV_*         slave indices into the one-hot select / per-slave buses
//   NSLV          number of slaves
//   DEF_*         default region map and timeout limit
//   in_region()   half-open BASE <= addr < TOP test
package mem_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam int unsigned NSLV      = 5;
  localparam int unsigned SLV_ROM   = 0;
  localparam int unsigned SLV_UART  = 1;
  localparam int unsigned SLV_CLINT = 2;
  localparam int unsigned SLV_CLIC  = 3;
  localparam int unsigned SLV_BRAM  = 4;

  localparam logic [31:0] DEF_ROM_BASE   = 32'h0000_0000;
  localparam logic [31:0] DEF_ROM_TOP    = 32'h0000_0100;
  localparam logic [31:0] DEF_UART_BASE  = 32'h0100_0000;
  localparam logic [31:0] DEF_UART_TOP   = 32'h0100_0004;
  localparam logic [31:0] DEF_CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] DEF_CLINT_TOP  = 32'h0200_C000;
  localparam logic [31:0] DEF_CLIC_BASE  = 32'h0300_0000;
  localparam logic [31:0] DEF_CLIC_TOP   = 32'h0300_1000;
  localparam logic [31:0] DEF_BRAM_BASE  = 32'h8000_0000;
  localparam logic [31:0] DEF_BRAM_TOP   = 32'h8010_0000;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  // Offset-from-base compare: one subtractor and one comparator, and it
  // stays correct for a region starting at address 0.
  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] top);
    return (addr - base) < (top - base);
  endfunction

endpackage

// File: rtl/mem_decoder_if.sv
// mem_decoder_if: bus between the arbiter memory port, the decoder and the
// SoC slaves.
//   memory_*  request from the arbiter / response back to it
//   slv_*     shared request to the slaves (one-hot slv_valid), per-slave
//             response data (slave i on slv_rdata[32i+31:32i]) and ready
// Modports: slave = decoder view, master = arbiter/slave-side environment.
interface mem_decoder_if;
  logic         memory_valid;
  logic         memory_instr;
  logic [31:0]  memory_addr;
  logic [31:0]  memory_wdata;
  logic [3:0]   memory_wstrb;
  logic [31:0]  memory_rdata;
  logic         memory_error;
  logic         memory_ready;

  logic [4:0]   slv_valid;
  logic         slv_instr;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_wstrb;
  logic [159:0] slv_rdata;
  logic [4:0]   slv_ready;

  modport slave (
    input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    output memory_rdata, memory_error, memory_ready,
    output slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb,
    input  slv_rdata, slv_ready
  );

  modport master (
    output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    input  memory_rdata, memory_error, memory_ready,
    input  slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb,
    output slv_rdata, slv_ready
  );
endinterface

// File: rtl/mem_decoder_addr_region_match.sv
// addr_region_match: combinational region decode.
//   addr_i       absolute byte address of the request
//   host_addr_i  tohost address, always routed to BRAM
//   hit_o        one-hot slave select (all zero = unmapped)
//   base_o       base address to subtract for the selected slave
// Priority: host match, then BRAM, CLIC, CLINT, UART, ROM.
module addr_region_match
  import mem_decoder_pkg::*;
#(
  parameter logic [31:0] ROM_BASE   = DEF_ROM_BASE,
  parameter logic [31:0] ROM_TOP    = DEF_ROM_TOP,
  parameter logic [31:0] UART_BASE  = DEF_UART_BASE,
  parameter logic [31:0] UART_TOP   = DEF_UART_TOP,
  parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
  parameter logic [31:0] CLINT_TOP  = DEF_CLINT_TOP,
  parameter logic [31:0] CLIC_BASE  = DEF_CLIC_BASE,
  parameter logic [31:0] CLIC_TOP   = DEF_CLIC_TOP,
  parameter logic [31:0] BRAM_BASE  = DEF_BRAM_BASE,
  parameter logic [31:0] BRAM_TOP   = DEF_BRAM_TOP
) (
  input  logic [31:0]     addr_i,
  input  logic [31:0]     host_addr_i,
  output logic [NSLV-1:0] hit_o,
  output logic [31:0]     base_o
);

  always_comb begin
    hit_o  = '0;
    base_o = '0;
    if (addr_i == host_addr_i) begin
      hit_o[SLV_BRAM] = 1'b1;
      base_o          = BRAM_BASE;
    end else if (in_region(addr_i, BRAM_BASE, BRAM_TOP)) begin
      hit_o[SLV_BRAM] = 1'b1;
      base_o          = BRAM_BASE;
    end else if (in_region(addr_i, CLIC_BASE, CLIC_TOP)) begin
      hit_o[SLV_CLIC] = 1'b1;
      base_o          = CLIC_BASE;
    end else if (in_region(addr_i, CLINT_BASE, CLINT_TOP)) begin
      hit_o[SLV_CLINT] = 1'b1;
      base_o           = CLINT_BASE;
    end else if (in_region(addr_i, UART_BASE, UART_TOP)) begin
      hit_o[SLV_UART] = 1'b1;
      base_o          = UART_BASE;
    end else if (in_region(addr_i, ROM_BASE, ROM_TOP)) begin
      hit_o[SLV_ROM] = 1'b1;
      base_o         = ROM_BASE;
    end
  end

endmodule

// File: rtl/mem_decoder.sv
// mem_decoder: address decoder and response router between the arbiter
// memory port and the rom/uart/clint/clic/bram slaves. One outstanding
// transaction; request path and response outputs are combinational.
//   clock      system clock
//   reset      asynchronous, active-high reset
//   host_addr  tohost address, always routed to BRAM
//   bus        mem_decoder_if.slave: arbiter request/response + slave buses
// Optional: define MEM_DECODER_TIMEOUT_EN to force an error response after
// TIMEOUT_CYCLES BUSY cycles without the selected slave's ready.
module mem_decoder
  import mem_decoder_pkg::*;
#(
  parameter logic [31:0] ROM_BASE       = DEF_ROM_BASE,
  parameter logic [31:0] ROM_TOP        = DEF_ROM_TOP,
  parameter logic [31:0] UART_BASE      = DEF_UART_BASE,
  parameter logic [31:0] UART_TOP       = DEF_UART_TOP,
  parameter logic [31:0] CLINT_BASE     = DEF_CLINT_BASE,
  parameter logic [31:0] CLINT_TOP      = DEF_CLINT_TOP,
  parameter logic [31:0] CLIC_BASE      = DEF_CLIC_BASE,
  parameter logic [31:0] CLIC_TOP       = DEF_CLIC_TOP,
  parameter logic [31:0] BRAM_BASE      = DEF_BRAM_BASE,
  parameter logic [31:0] BRAM_TOP       = DEF_BRAM_TOP,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  host_addr,
  mem_decoder_if.slave bus
);

  state_t          state_q, state_d;
  logic [NSLV-1:0] sel_q, sel_d;
  logic [NSLV-1:0] hit;
  logic [31:0]     base;
  logic            mapped;
  logic            can_accept;
  logic            start_busy;
  logic            ready_sel;
  logic [31:0]     rdata_sel;

  addr_region_match #(
    .ROM_BASE  (ROM_BASE),   .ROM_TOP  (ROM_TOP),
    .UART_BASE (UART_BASE),  .UART_TOP (UART_TOP),
    .CLINT_BASE(CLINT_BASE), .CLINT_TOP(CLINT_TOP),
    .CLIC_BASE (CLIC_BASE),  .CLIC_TOP (CLIC_TOP),
    .BRAM_BASE (BRAM_BASE),  .BRAM_TOP (BRAM_TOP)
  ) u_match (
    .addr_i     (bus.memory_addr),
    .host_addr_i(host_addr),
    .hit_o      (hit),
    .base_o     (base)
  );

  assign mapped        = |hit;
  assign start_busy    = can_accept && bus.memory_valid && mapped;

  assign bus.slv_instr = bus.memory_instr;
  assign bus.slv_addr  = bus.memory_addr - base;
  assign bus.slv_wdata = bus.memory_wdata;
  assign bus.slv_wstrb = bus.memory_wstrb;

  // sel_q is one-hot, so masking ignores every ready/rdata but the selected one.
  assign ready_sel = |(bus.slv_ready & sel_q);

  always_comb begin
    rdata_sel = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (sel_q[i]) rdata_sel = rdata_sel | bus.slv_rdata[32*i +: 32];
    end
  end

`ifdef MEM_DECODER_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;

  // cnt_q counts completed BUSY cycles, so the current one is cnt_q+1.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (start_busy)             cnt_d = '0;
    else if (state_q == BUSY)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  // Parameter kept for drop-in compatibility when the timeout is compiled out.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    can_accept       = 1'b0;
    bus.slv_valid    = '0;
    bus.memory_ready = 1'b0;
    bus.memory_error = 1'b0;
    bus.memory_rdata = '0;

    case (state_q)
      IDLE: can_accept = 1'b1;
      BUSY: begin
        if (ready_sel) begin
          bus.memory_ready = 1'b1;
          bus.memory_rdata = rdata_sel;
          state_d          = IDLE;
          can_accept       = 1'b1;
        end
`ifdef MEM_DECODER_TIMEOUT_EN
        else if (timeout_hit) begin
          bus.memory_ready = 1'b1;
          bus.memory_error = 1'b1;
          state_d          = IDLE;
          can_accept       = 1'b1;
        end
`endif
      end
      ERR: begin
        bus.memory_ready = 1'b1;
        bus.memory_error = 1'b1;
        state_d          = IDLE;
        can_accept       = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A response cycle doubles as an accept cycle for zero-bubble issue.
    if (can_accept && bus.memory_valid) begin
      if (mapped) begin
        bus.slv_valid = hit;
        sel_d         = hit;
        state_d       = BUSY;
      end else begin
        state_d = ERR;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_mem_decoder.sv
// tb_mem_decoder: self-checking bench for mem_decoder; directed scenarios
// plus randomized transactions checked against a region-table model.
module tb_mem_decoder;

`ifdef MEM_DECODER_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  // Region table indexed by slave number: ROM, UART, CLINT, CLIC, BRAM.
  localparam logic [31:0] RB [0:4] = '{32'h0000_0000, 32'h0100_0000,
                                       32'h0200_0000, 32'h0300_0000, 32'h8000_0000};
  localparam logic [31:0] RT [0:4] = '{32'h0000_0100, 32'h0100_0004,
                                       32'h0200_C000, 32'h0300_1000, 32'h8010_0000};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] host_addr;
  int          tests = 0;
  int          failed = 0;

  mem_decoder_if bus ();

  mem_decoder #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clock    (clock),
    .reset    (reset),
    .host_addr(host_addr),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference decode: -1 for unmapped, otherwise slave index; BRAM first.
  function automatic int ref_slave(input logic [31:0] a, input logic [31:0] h);
    if (a == h) return 4;
    for (int i = 4; i >= 0; i--)
      if (longint'(a) >= longint'(RB[i]) && longint'(a) < longint'(RT[i])) return i;
    return -1;
  endfunction

  task automatic idle_inputs;
    bus.memory_valid = 1'b0;
    bus.memory_instr = 1'b0;
    bus.memory_addr  = '0;
    bus.memory_wdata = '0;
    bus.memory_wstrb = '0;
    bus.slv_rdata    = '0;
    bus.slv_ready    = '0;
  endtask

  // One full transaction from IDLE back to IDLE with 'lat' non-ready BUSY
  // cycles; 'noise' raises ready on non-selected slaves throughout.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                         input int lat, input logic [31:0] data, input logic [4:0] noise);
    int          idx;
    logic [4:0]  exp_sv;
    logic [31:0] wd, off;
    logic        ins;
    idx    = ref_slave(addr, host_addr);
    exp_sv = (idx < 0) ? 5'd0 : 5'(1 << idx);
    off    = (idx < 0) ? 32'd0 : addr - RB[idx];
    wd     = $urandom;
    ins    = 1'($urandom_range(0, 1));
    bus.memory_valid = 1'b1;
    bus.memory_addr  = addr;
    bus.memory_wdata = wd;
    bus.memory_wstrb = wstrb;
    bus.memory_instr = ins;
    bus.slv_ready    = '0;
    #1;
    tests++;
    if (bus.slv_valid !== exp_sv) begin
      failed++;
      $display("FAIL slv_valid addr=%h: got %b expected %b", addr, bus.slv_valid, exp_sv);
    end
    if (idx >= 0) begin
      tests++;
      if ({bus.slv_addr, bus.slv_wdata, bus.slv_wstrb, bus.slv_instr} !== {off, wd, wstrb, ins}) begin
        failed++;
        $display("FAIL slv_fields addr=%h: got %h/%h/%h/%b expected %h/%h/%h/%b", addr,
                 bus.slv_addr, bus.slv_wdata, bus.slv_wstrb, bus.slv_instr, off, wd, wstrb, ins);
      end
    end
    tests++;
    if (bus.memory_ready !== 1'b0) begin
      failed++;
      $display("FAIL idle_ready addr=%h: got %b expected 0", addr, bus.memory_ready);
    end
    tick;
    bus.memory_valid = 1'b0;
    if (idx < 0) begin
      #1;
      tests++;
      if ({bus.memory_ready, bus.memory_error, bus.memory_rdata} !== {2'b11, 32'd0}) begin
        failed++;
        $display("FAIL err_resp addr=%h: got %b%b %h expected 11 00000000", addr,
                 bus.memory_ready, bus.memory_error, bus.memory_rdata);
      end
      tick;
    end else begin
      for (int k = 0; k < lat; k++) begin
        bus.slv_ready = noise & ~exp_sv;
        bus.slv_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom};
        #1;
        tests++;
        if ({bus.memory_ready, bus.memory_error, bus.memory_rdata} !== 34'd0) begin
          failed++;
          $display("FAIL busy_wait addr=%h cyc=%0d: got %b%b %h expected 00 00000000", addr, k,
                   bus.memory_ready, bus.memory_error, bus.memory_rdata);
        end
        tick;
      end
      bus.slv_ready = exp_sv | noise;
      for (int s = 0; s < 5; s++) bus.slv_rdata[32*s +: 32] = (s == idx) ? data : $urandom;
      #1;
      tests++;
      if ({bus.memory_ready, bus.memory_error, bus.memory_rdata} !== {2'b10, data}) begin
        failed++;
        $display("FAIL resp addr=%h: got %b%b %h expected 10 %h", addr,
                 bus.memory_ready, bus.memory_error, bus.memory_rdata, data);
      end
      tick;
      bus.slv_ready = '0;
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    host_addr = 32'hFFFF_FFF0;
    reset = 1'b1;
    #2;
    tests++;
    if ({bus.slv_valid, bus.memory_ready, bus.memory_error, bus.memory_rdata} !== 39'd0) begin
      failed++;
      $display("FAIL reset_outputs: got %b %b%b %h expected all zero",
               bus.slv_valid, bus.memory_ready, bus.memory_error, bus.memory_rdata);
    end
    tick;
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_directed;
    run_txn(32'h8000_0010, 4'h0, 1, 32'hDEAD_BEEF, 5'd0);
    run_txn(32'h0200_4000, 4'hF, 0, 32'h0000_1234, 5'd0);
    run_txn(32'h4000_0000, 4'h0, 0, 32'd0, 5'd0);
    host_addr = 32'h8000_1000;
    run_txn(32'h8000_1000, 4'h0, 0, 32'hA5A5_0001, 5'd0);
    host_addr = 32'h1000_0000;
    run_txn(32'h1000_0000, 4'h3, 2, 32'hA5A5_0002, 5'h0F);
    host_addr = 32'hFFFF_FFF0;
  endtask

  task automatic test_boundaries;
    logic [31:0] edges [0:7];
    edges = '{32'h0000_00FF, 32'h0000_0100, 32'h0100_0003, 32'h0100_0004,
              32'h0200_BFFF, 32'h0200_C000, 32'h0300_1000, 32'h8010_0000};
    foreach (edges[i]) run_txn(edges[i], 4'h0, 0, $urandom, 5'd0);
  endtask

  task automatic test_back_to_back;
    // ROM busy with spurious UART ready and a dropped request
    bus.memory_valid = 1'b1; bus.memory_addr = 32'h20; bus.memory_wstrb = 4'h0;
    tick;
    bus.memory_valid = 1'b1; bus.memory_addr = 32'h8000_0000;
    bus.slv_ready = 5'b00010; bus.slv_rdata[63:32] = 32'h1111_1111;
    #1;
    tests++;
    if ({bus.slv_valid, bus.memory_ready} !== 6'd0) begin
      failed++;
      $display("FAIL busy_drop: got %b %b expected 00000 0", bus.slv_valid, bus.memory_ready);
    end
    tick;
    bus.memory_valid = 1'b0;
    // ROM ready in the same cycle as a new UART request
    bus.slv_ready = 5'b00011; bus.slv_rdata[31:0] = 32'hC0FF_EE01;
    bus.memory_valid = 1'b1; bus.memory_addr = 32'h0100_0000; bus.memory_wstrb = 4'hF;
    #1;
    tests++;
    if ({bus.memory_ready, bus.memory_error, bus.memory_rdata, bus.slv_valid, bus.slv_addr}
        !== {2'b10, 32'hC0FF_EE01, 5'b00010, 32'd0}) begin
      failed++;
      $display("FAIL b2b_handoff: got %b%b %h %b %h expected 10 c0ffee01 00010 00000000",
               bus.memory_ready, bus.memory_error, bus.memory_rdata, bus.slv_valid, bus.slv_addr);
    end
    tick;
    bus.memory_valid = 1'b0;
    bus.slv_ready = 5'b00001;
    #1;
    tests++;
    if (bus.memory_ready !== 1'b0) begin
      failed++;
      $display("FAIL uart_stale_rom: got %b expected 0", bus.memory_ready);
    end
    bus.slv_ready = 5'b00010; bus.slv_rdata[63:32] = 32'h0000_0055;
    #1;
    tests++;
    if ({bus.memory_ready, bus.memory_error, bus.memory_rdata} !== {2'b10, 32'h55}) begin
      failed++;
      $display("FAIL uart_resp: got %b%b %h expected 10 00000055",
               bus.memory_ready, bus.memory_error, bus.memory_rdata);
    end
    tick;
    bus.slv_ready = '0;
    // Request accepted during the ERR response cycle
    bus.memory_valid = 1'b1; bus.memory_addr = 32'h4000_0000;
    tick;
    bus.memory_addr = 32'h8000_0008;
    #1;
    tests++;
    if ({bus.memory_ready, bus.memory_error, bus.memory_rdata, bus.slv_valid, bus.slv_addr}
        !== {2'b11, 32'd0, 5'b10000, 32'h8}) begin
      failed++;
      $display("FAIL err_accept: got %b%b %h %b %h expected 11 00000000 10000 00000008",
               bus.memory_ready, bus.memory_error, bus.memory_rdata, bus.slv_valid, bus.slv_addr);
    end
    tick;
    bus.memory_valid = 1'b0;
    bus.slv_ready = 5'b10000; bus.slv_rdata[159:128] = 32'h0000_00AB;
    #1;
    tests++;
    if ({bus.memory_ready, bus.memory_error, bus.memory_rdata} !== {2'b10, 32'hAB}) begin
      failed++;
      $display("FAIL err_accept_resp: got %b%b %h expected 10 000000ab",
               bus.memory_ready, bus.memory_error, bus.memory_rdata);
    end
    tick;
    bus.slv_ready = '0;
  endtask

  task automatic test_random;
    int          r, reg_i;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      r     = $urandom_range(0, 9);
      reg_i = $urandom_range(0, 4);
      host_addr = ($urandom_range(0, 3) == 0) ? RB[reg_i] + 32'h40 : 32'hFFFF_FFF0;
      case (r)
        0, 1, 2, 3, 4: a = RB[reg_i] + ($urandom % (RT[reg_i] - RB[reg_i]));
        5:             a = RT[reg_i];
        6:             a = RB[reg_i] - 32'd1;
        7:             a = $urandom;
        8:             a = host_addr;
        default:       a = RB[reg_i];
      endcase
      run_txn(a, 4'($urandom), $urandom_range(0, 3), $urandom, 5'($urandom));
    end
    host_addr = 32'hFFFF_FFF0;
  endtask

  task automatic test_reset_midflight;
    bus.memory_valid = 1'b1; bus.memory_addr = 32'h8000_0040; bus.memory_wstrb = 4'h0;
    tick;
    bus.memory_valid = 1'b0;
    bus.slv_ready = 5'b10000; bus.slv_rdata[159:128] = 32'h0000_0077;
    reset = 1'b1;
    #1;
    tests++;
    if ({bus.memory_ready, bus.memory_error, bus.memory_rdata} !== 34'd0) begin
      failed++;
      $display("FAIL reset_busy: got %b%b %h expected 00 00000000",
               bus.memory_ready, bus.memory_error, bus.memory_rdata);
    end
    tick;
    reset = 1'b0;
    #1;
    tests++;
    if (bus.memory_ready !== 1'b0) begin
      failed++;
      $display("FAIL late_ready_after_reset: got %b expected 0", bus.memory_ready);
    end
    tick;
    bus.slv_ready = '0;
  endtask

`ifdef MEM_DECODER_TIMEOUT_EN
  task automatic test_timeout;
    bus.memory_valid = 1'b1; bus.memory_addr = 32'h8000_0100; bus.memory_wstrb = 4'h0;
    tick;
    bus.memory_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      tests++;
      if (bus.memory_ready !== 1'b0) begin
        failed++;
        $display("FAIL timeout_early cyc=%0d: got %b expected 0", c, bus.memory_ready);
      end
      tick;
    end
    tests++;
    if ({bus.memory_ready, bus.memory_error, bus.memory_rdata} !== {2'b11, 32'd0}) begin
      failed++;
      $display("FAIL timeout_resp: got %b%b %h expected 11 00000000",
               bus.memory_ready, bus.memory_error, bus.memory_rdata);
    end
    tick;
    bus.slv_ready = 5'b10000; bus.slv_rdata[159:128] = 32'h0000_0099;
    #1;
    tests++;
    if (bus.memory_ready !== 1'b0) begin
      failed++;
      $display("FAIL timeout_stale: got %b expected 0", bus.memory_ready);
    end
    tick;
    bus.slv_ready = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_boundaries();
    test_back_to_back();
    test_random();
`ifdef MEM_DECODER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_decoder.md
Name: mem_decoder

Overview:
- Registered address decoder and response router between the `arbiter` memory port and the SoC slaves: `rom`, `uart`, `clint`, `clic` and `bram`.
- Decodes each request strobe, forwards it to exactly one slave with the slave's base address subtracted, and tracks the single outstanding transaction.
- Returns only the selected slave's response to the master.
- Generates a one-cycle-delayed error response for unmapped addresses.

Parameters:
- ROM_BASE, 32'h00000000, ROM region start (inclusive)
- ROM_TOP, 32'h00000100, ROM region end (exclusive)
- UART_BASE, 32'h01000000, UART region start
- UART_TOP, 32'h01000004, UART region end
- CLINT_BASE, 32'h02000000, CLINT region start
- CLINT_TOP, 32'h0200C000, CLINT region end
- CLIC_BASE, 32'h03000000, CLIC region start
- CLIC_TOP, 32'h03001000, CLIC region end
- BRAM_BASE, 32'h80000000, BRAM region start
- BRAM_TOP, 32'h80100000, BRAM region end
- TIMEOUT_CYCLES, 255, BUSY-cycle limit before forced error (used only with the optional feature)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- host_addr  in  32  tohost word address; always routed to BRAM
- memory_valid  in  1  request strobe from arbiter, one cycle per request
- memory_instr  in  1  instruction-fetch qualifier
- memory_addr  in  32  absolute byte address
- memory_wdata  in  32  write data
- memory_wstrb  in  4  byte strobes; 0 = read
- memory_rdata  out  32  response data to arbiter
- memory_error  out  1  error response
- memory_ready  out  1  response strobe
- slv_valid  out  5  one-hot request strobe; bit 0 ROM, 1 UART, 2 CLINT, 3 CLIC, 4 BRAM
- slv_instr  out  1  shared copy of memory_instr
- slv_addr  out  32  shared address, offset from the selected slave's base
- slv_wdata  out  32  shared write data
- slv_wstrb  out  4  shared byte strobes
- slv_rdata  in  160  per-slave read data; slave i uses bits [32i+31:32i]
- slv_ready  in  5  per-slave response strobe

Behaviour:
- Reset values (asynchronous): state=IDLE, sel=0, slv_valid=0, memory_ready=0, memory_error=0, memory_rdata=0.
- Request path is combinational.
  - slv_valid is driven in the same cycle memory_valid is high and state accepts.
  - slv_addr = memory_addr - base of the selected region.
- Decode priority:
  1. memory_addr==host_addr → BRAM, base BRAM_BASE.
  2. Then BRAM, CLIC, CLINT, UART, ROM range matches, each as BASE <= addr < TOP.
  3. Otherwise unmapped.
- States:
  - IDLE:
    - valid with mapped address → latch sel, go to BUSY.
    - valid with unmapped address → go to ERR.
  - BUSY:
    - Wait for slv_ready[sel].
    - In that cycle: memory_ready=1, memory_rdata=slv_rdata[sel], memory_error=0.
    - Return to IDLE in the same cycle, so a new memory_valid in that cycle is accepted (back-to-back, zero bubble).
  - ERR:
    - Exactly one cycle after the request: memory_ready=1, memory_error=1, memory_rdata=0.
    - Then go to IDLE; a memory_valid in the ERR cycle is accepted.
- Response outputs are combinational from state and slv_ready/slv_rdata; they are 0 whenever no response is given.
- slv_ready bits other than sel are ignored in every state; so is any slv_ready bit seen in IDLE.
- memory_valid while BUSY (not in the ready cycle) is a protocol violation: the request is dropped and no slave is strobed.
- Address arithmetic is modulo 2^32.
- TOP is exclusive: an access at exactly a region's TOP falls through to the next region or to unmapped.
- Reset asserted mid-transaction aborts it; a slave's late ready after reset release is ignored because state=IDLE.

Optional Feature:
- Macro: MEM_DECODER_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without slv_ready[sel], the decoder returns memory_ready=1, memory_error=1, memory_rdata=0 that cycle and goes to IDLE.
  - A slave ready arriving in the same cycle as the timeout wins and gives a normal response.
  - A later stale ready is ignored.
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- Shared package mem_decoder_pkg:
  - state enum {IDLE, BUSY, ERR};
  - slave index constants SLV_ROM..SLV_BRAM;
  - NSLV=5.
- Region defaults come from the existing configuration constants.
- One sub-module, addr_region_match: combinational BASE/TOP compare producing the one-hot select and the base to subtract.

Test Plan:
- Read 0x80000010 with bram ready 2 cycles later, rdata 0xDEADBEEF → slv_valid=5'b10000, slv_addr=0x10, memory_ready with rdata 0xDEADBEEF, error=0.
- Write 0x02004000, wstrb=4'hF, clint ready next cycle → slv_valid=5'b00100, slv_addr=0x4000, memory_ready=1, error=0.
- Access to 0x40000000 → no slv_valid; one cycle later memory_ready=1, error=1, rdata=0.
- host_addr=0x80001000 and access to 0x80001000 → routed to BRAM with slv_addr=0x1000. Also: host_addr=0x10000000 and access to 0x10000000 → routed to BRAM (host match overrides unmapped) with slv_addr=0x90000000 (0x10000000-0x80000000 mod 2^32).
- ROM ready in the same cycle as a new valid to UART 0x01000000 → ROM response returned and UART strobed the same cycle. Also: spurious uart ready while ROM is busy → ignored.
- MEM_DECODER_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no slave ready → error response after 4 BUSY cycles; a later stale ready is ignored. Also: reset asserted in BUSY → all outputs 0 immediately.
